alu_multicycle: RTL
===================

// Module: alu_multicycle
// PURPOSE
//  Parametrised, registered ALU for the multi-cycle datapath. Executes the existing
//  AND/OR/ADD/SUB/SLT/NOR set in one cycle. Adds iterative unsigned multiply (shift-add)
//  and unsigned divide (restoring), each WIDTH cycles. Start/busy/done handshake to the
//  control FSM; writes a HI/LO result pair.
// PARAMETERS
//  WIDTH   32  operand/result width in bits (>=4)
//  CNT_W   $clog2(WIDTH)+1  iteration counter width (derived; do not override)
// PORTS
//  clk             in   1      rising-edge clock
//  rst_n           in   1      asynchronous, active-low reset
//  start_in        in   1      accept op when high and busy_out low
//  alu_control_in  in   4      op code (cpu_constant_library encodings)
//  channel_a_in    in   WIDTH  operand A, sampled at accept
//  channel_b_in    in   WIDTH  operand B, sampled at accept
//  busy_out        out  1      op in flight; start_in ignored
//  done_out        out  1      one-cycle pulse; results valid this cycle, held until next accept
//  alu_result_out  out  WIDTH  result / product LO / quotient
//  hi_out          out  WIDTH  product HI / remainder; 0 for single-cycle ops
//  zero_out        out  1      alu_result_out == 0
//  overflow_out    out  1      signed overflow (ADD/SUB only), else 0
//  div_zero_out    out  1      DIVU with B == 0
// BEHAVIOUR
//  - Reset (async on rst_n low): state=IDLE; all outputs 0; counter 0; operand regs 0.
//  - FSM: IDLE -> (accept, 1-cycle op) DONE; IDLE -> MUL or DIV; MUL/DIV -> DONE when
//    counter reaches WIDTH; DONE -> IDLE. Accept is legal in DONE, same as IDLE.
//  - Accept: start_in & ~busy_out at edge t. busy_out high from t+1 until done.
//  - Latency: 1-cycle ops, done_out at t+1. MUL/DIVU, done_out at t+WIDTH+1.
//  - Ops: AND, OR, NOR bitwise. ADD/SUB modulo 2^WIDTH with signed overflow flag.
//    SLT: all-ones if $signed(A)<$signed(B), else 0. MULT (4'b1000): {hi,lo}=A*B unsigned,
//    2*WIDTH bits. DIVU (4'b1001): lo=A/B, hi=A%B unsigned.
//  - Undefined op code: result 0, hi 0, zero_out 1, completes in 1 cycle.
//  - zero_out computed from alu_result_out only; updated with done_out.
//  - DIVU with B==0: no iteration; done at t+1, lo=all-ones, hi=A, div_zero_out=1.
//  - MULT with A or B zero still takes full WIDTH cycles (fixed latency).
//  - start_in while busy: ignored, no queueing, in-flight op unaffected.
//  - start_in on same edge done_out is high: accepted (back-to-back).
//  - Outputs hold last result between ops. Results may change only on done_out.
//  - rst_n low mid-op: abort immediately; no done_out pulse; outputs cleared.
// CONFIGURATION
//  ALU_MULDIV_EN defined: MUL/DIV states, counter and shift regs built as above.
//  ALU_MULDIV_EN undefined: MULT/DIVU treated as undefined op codes (1 cycle, result 0,
//  div_zero_out tied 0). No MUL/DIV states or iteration logic synthesised.
// TESTING (WIDTH=32, ALU_MULDIV_EN defined unless stated)
//  1. ADD 0x7FFFFFFF+1 -> done at t+1, result 0x80000000, overflow 1, zero 0, hi 0.
//  2. SUB 5-5 then SLT -1<1 back-to-back -> result 0 with zero 1, then 0xFFFFFFFF.
//  3. MULT 0xFFFFFFFF*2 -> busy 32 cycles, done at t+33, hi 0x1, lo 0xFFFFFFFE.
//  4. DIVU 100/7 -> done t+33, lo 14, hi 2. DIVU 9/0 -> done t+1, lo 0xFFFFFFFF, hi 9, div_zero 1.
//  5. MULT accepted, start_in pulsed at t+5, rst_n low at t+10 -> op ignored, no done, outputs 0.
//  6. ALU_MULDIV_EN undefined: MULT 3*4 -> done t+1, result 0, zero 1, busy never >1 cycle.

Source files
------------

// File: rtl/alu_multicycle.sv
`default_nettype none
// ============================================================================
// Module   : alu_multicycle
// Purpose  : Registered ALU for the multi-cycle datapath. AND/OR/ADD/SUB/SLT/
//            NOR complete one cycle after accept. When ALU_MULDIV_EN is
//            defined, MULT (shift-add) and DIVU (restoring) iterate for WIDTH
//            cycles and return a HI/LO pair. Without ALU_MULDIV_EN those two
//            codes behave as undefined op codes.
// Ports    : clk, rst_n (async, active low)
//            start_in, alu_control_in[3:0], channel_a_in, channel_b_in
//            busy_out, done_out, alu_result_out, hi_out,
//            zero_out, overflow_out, div_zero_out
// Macro    : ALU_MULDIV_EN - builds the multiply/divide iteration logic
// Revision : 1.0 - initial release
// ============================================================================
module alu_multicycle #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_in,
  input  logic [3:0]       alu_control_in,
  input  logic [WIDTH-1:0] channel_a_in,
  input  logic [WIDTH-1:0] channel_b_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] alu_result_out,
  output logic [WIDTH-1:0] hi_out,
  output logic             zero_out,
  output logic             overflow_out,
  output logic             div_zero_out
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
`ifdef ALU_MULDIV_EN
  localparam logic [3:0] OP_MULT = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DONE = 2'd1
`ifdef ALU_MULDIV_EN
    ,
    S_MUL  = 2'd2,
    S_DIV  = 2'd3
`endif
  } state_t;

  state_t state;
  state_t next_state;

  logic accept;
  logic single_load;

  // Single-cycle result path, evaluated on the live inputs at accept.
  logic [WIDTH-1:0] sc_result;
  logic [WIDTH-1:0] sc_hi;
  logic             sc_ovf;
  logic             sc_dz;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             a_msb;
  logic             b_msb;

  assign accept      = start_in & ~busy_out;
  assign done_out    = (state == S_DONE);
  // Only the accept path can jump straight to DONE; iteration ends are
  // handled separately in the datapath.
  assign single_load = accept & (next_state == S_DONE);

  assign sum   = channel_a_in + channel_b_in;
  assign diff  = channel_a_in - channel_b_in;
  assign a_msb = channel_a_in[WIDTH-1];
  assign b_msb = channel_b_in[WIDTH-1];

  always_comb begin
    sc_result = '0;
    sc_hi     = '0;
    sc_ovf    = 1'b0;
    sc_dz     = 1'b0;
    case (alu_control_in)
      OP_AND: sc_result = channel_a_in & channel_b_in;
      OP_OR:  sc_result = channel_a_in | channel_b_in;
      OP_NOR: sc_result = ~(channel_a_in | channel_b_in);
      OP_ADD: begin
        sc_result = sum;
        sc_ovf    = (a_msb == b_msb) && (sum[WIDTH-1] != a_msb);
      end
      OP_SUB: begin
        sc_result = diff;
        sc_ovf    = (a_msb != b_msb) && (diff[WIDTH-1] != a_msb);
      end
      OP_SLT: sc_result = {WIDTH{$signed(channel_a_in) < $signed(channel_b_in)}};
`ifdef ALU_MULDIV_EN
      // A zero divisor short-circuits to a one-cycle result; non-zero
      // divisors never reach this path because they go to S_DIV.
      OP_DIVU: begin
        sc_result = '1;
        sc_hi     = channel_a_in;
        sc_dz     = 1'b1;
      end
`endif
      default: ;
    endcase
  end

`ifdef ALU_MULDIV_EN
  // Shared work registers: hi accumulates partial product / remainder,
  // lo shifts out the multiplier / shifts in quotient bits.
  logic [WIDTH-1:0] work_hi;
  logic [WIDTH-1:0] work_lo;
  logic [WIDTH-1:0] op_b;
  logic [CNT_W-1:0] cnt;
  logic             last_step;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_trial;
  logic             div_ok;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  assign busy_out  = (state == S_MUL) || (state == S_DIV);
  assign last_step = (cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, op_b} : '0);
    // {rem, next dividend bit} is below 2*divisor, so the trial difference
    // is non-negative exactly when its top bit is clear.
    div_trial = {work_hi, work_lo[WIDTH-1]} - {1'b0, op_b};
    div_ok    = ~div_trial[WIDTH];
    if (state == S_DIV) begin
      step_hi = div_ok ? div_trial[WIDTH-1:0] : {work_hi[WIDTH-2:0], work_lo[WIDTH-1]};
      step_lo = {work_lo[WIDTH-2:0], div_ok};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], work_lo[WIDTH-1:1]};
    end
  end
`else
  assign busy_out = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (accept) begin
          next_state = S_DONE;
`ifdef ALU_MULDIV_EN
          if (alu_control_in == OP_MULT)
            next_state = S_MUL;
          else if (alu_control_in == OP_DIVU && channel_b_in != '0)
            next_state = S_DIV;
`endif
        end else if (state == S_DONE) begin
          next_state = S_IDLE;
        end
      end
`ifdef ALU_MULDIV_EN
      S_MUL, S_DIV: if (last_step) next_state = S_DONE;
`endif
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_result_out <= '0;
      hi_out         <= '0;
      zero_out       <= 1'b0;
      overflow_out   <= 1'b0;
      div_zero_out   <= 1'b0;
`ifdef ALU_MULDIV_EN
      work_hi        <= '0;
      work_lo        <= '0;
      op_b           <= '0;
      cnt            <= '0;
`endif
    end else begin
      if (single_load) begin
        alu_result_out <= sc_result;
        hi_out         <= sc_hi;
        zero_out       <= (sc_result == '0);
        overflow_out   <= sc_ovf;
        div_zero_out   <= sc_dz;
      end
`ifdef ALU_MULDIV_EN
      if (accept) begin
        // Multiply and divide start from the same register image.
        work_hi <= '0;
        work_lo <= channel_a_in;
        op_b    <= channel_b_in;
        cnt     <= '0;
      end else if (busy_out) begin
        work_hi <= step_hi;
        work_lo <= step_lo;
        cnt     <= cnt + 1'b1;
        if (last_step) begin
          alu_result_out <= step_lo;
          hi_out         <= step_hi;
          zero_out       <= (step_lo == '0);
          overflow_out   <= 1'b0;
          div_zero_out   <= 1'b0;
        end
      end
`endif
    end
  end

endmodule
`default_nettype wire
